// File: rtl/uart_sample_packetizer_pkg.sv
// Shared definitions for the UART sample packetizer: state encoding, sizing helpers
// and the byte-wide checksum helper.
package uart_sample_packetizer_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Bytes needed to carry one sample (MSB zero-extended to a whole byte).
    function automatic int calc_bps(input int sample_width);
        return (sample_width + 7) / 8;
    endfunction

    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/uart_sample_packetizer_sync_fifo.sv
// Synchronous FIFO with registered count/full/empty and show-ahead read data.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nx_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full_r;
    assign pop_ok_s  = pop && !empty_r;

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nx_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_nx_s = count_r + CW'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_nx_s = count_r - CW'(1);
        end else begin
            count_nx_s = count_r;
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and registered status flags; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nx_s;
            full_r  <= (count_nx_s == CW'(DEPTH));
            empty_r <= (count_nx_s == CW'(0));
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign full    = full_r;
    assign empty   = empty_r;

endmodule

// File: rtl/uart_sample_packetizer.sv
// Buffers capture-path samples and frames them as SYNC, sample bytes MSB-first, XOR checksum,
// handing one byte at a time to uart_tx and waiting for each tx_done.
module uart_sample_packetizer
    import uart_sample_packetizer_pkg::*;
#(
    parameter int         SAMPLE_WIDTH       = 16,
    parameter int         SAMPLES_PER_PACKET = 4,
    parameter int         FIFO_DEPTH         = 16,
    parameter logic [7:0] SYNC_BYTE          = SYNC_BYTE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    input  logic [SAMPLE_WIDTH-1:0] s_data,
    output logic                    s_ready,
    output logic                    tx_data_valid,
    output logic [7:0]              tx_byte,
    input  logic                    tx_active,
    input  logic                    tx_done,
    output logic                    overflow,
    output logic                    busy
);

    localparam int BPS      = calc_bps(SAMPLE_WIDTH);
    localparam int LAST_IDX = SAMPLES_PER_PACKET * BPS + 1;
    localparam int IDX_W    = $clog2(LAST_IDX + 1);
    localparam int POS_W    = (BPS > 1) ? $clog2(BPS) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(BPS - 1);

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [IDX_W-1:0]        idx_r;
    logic [IDX_W-1:0]        idx_nx_s;
    logic [POS_W-1:0]        pos_r;
    logic [POS_W-1:0]        pos_nx_s;
    logic [7:0]              cksum_r;
    logic [7:0]              cksum_nx_s;
    logic                    tx_data_valid_r;
    logic [7:0]              tx_byte_r;
    logic                    busy_r;
    logic                    overflow_r;
    logic                    launch_s;
    logic [7:0]              launch_byte_s;
    logic                    pop_s;
    logic                    push_s;
    logic [SAMPLE_WIDTH-1:0] head_s;
    logic [CNT_W-1:0]        fifo_count_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [BPS*8-1:0]        padded_s;
    logic [7:0]              sample_byte_s;

    assign push_s = s_valid && !fifo_full_s;

    sync_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (s_data),
        .rd_data (head_s),
        .count   (fifo_count_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Byte mux: pos_r counts down from the MSB byte of the head sample.
    always_comb begin
        padded_s                   = {(BPS*8){1'b0}};
        padded_s[SAMPLE_WIDTH-1:0] = head_s;
        sample_byte_s              = 8'(padded_s >> {pos_r, 3'b000});
    end

    // Next-state, launch and byte-sequencing logic.
    always_comb begin
        state_nx_s    = state_r;
        idx_nx_s      = idx_r;
        pos_nx_s      = pos_r;
        cksum_nx_s    = cksum_r;
        launch_s      = 1'b0;
        launch_byte_s = tx_byte_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fifo_count_s >= CNT_W'(SAMPLES_PER_PACKET)) begin
                    state_nx_s = ST_SEND;
                    idx_nx_s   = IDX_W'(0);
                    pos_nx_s   = POS_LAST;
                    cksum_nx_s = 8'h00;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!tx_active) begin
                    launch_s   = 1'b1;
                    state_nx_s = ST_WAIT;
                    if (idx_r == IDX_W'(0)) begin
                        launch_byte_s = SYNC_BYTE;
                    end else if (idx_r == IDX_W'(LAST_IDX)) begin
                        launch_byte_s = cksum_r;
                    end else begin
                        launch_byte_s = sample_byte_s;
                        cksum_nx_s    = xor_fold(cksum_r, sample_byte_s);
                        pop_s         = (pos_r == POS_W'(0)) && !fifo_empty_s;
                    end
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (idx_r == IDX_W'(LAST_IDX)) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_SEND;
                        idx_nx_s   = idx_r + IDX_W'(1);
                        // SYNC does not consume a sample byte position.
                        if (idx_r != IDX_W'(0)) begin
                            pos_nx_s = (pos_r == POS_W'(0)) ? POS_LAST : pos_r - POS_W'(1);
                        end else begin
                            pos_nx_s = pos_r;
                        end
                    end
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, sequencing counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            idx_r           <= IDX_W'(0);
            pos_r           <= POS_LAST;
            cksum_r         <= 8'h00;
            tx_data_valid_r <= 1'b0;
            tx_byte_r       <= 8'h00;
            busy_r          <= 1'b0;
            overflow_r      <= 1'b0;
        end else begin
            state_r         <= state_nx_s;
            idx_r           <= idx_nx_s;
            pos_r           <= pos_nx_s;
            cksum_r         <= cksum_nx_s;
            tx_data_valid_r <= launch_s;
            tx_byte_r       <= launch_byte_s;
            busy_r          <= (state_nx_s != ST_IDLE);
            overflow_r      <= overflow_r | (s_valid & fifo_full_s);
        end
    end

    assign s_ready       = !fifo_full_s;
    assign tx_data_valid = tx_data_valid_r;
    assign tx_byte       = tx_byte_r;
    assign busy          = busy_r;
    assign overflow      = overflow_r;

endmodule
